apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//   APB completer that sits directly downstream of the APB master and terminates its transfers.
//   Holds a bank of DEPTH 32-bit read/write registers indexed by PADDR.
//   Inserts a programmable number of wait states and flags out-of-range accesses with PSLVERR.
//   Provides the PREADY/PRDATA return path the master waits on.
// PARAMETERS
//   DEPTH        16  number of 32-bit registers; valid index range 0..DEPTH-1 (DEPTH <= 256)
//   WAIT_CYCLES  1   wait states per transfer: PREADY is held 0 for this many ACCESS cycles
//   RST_VAL      0   reset/clear value of every register
// PORTS
//   PCLK     in   1   clock; all logic on rising edge
//   PRESET   in   1   reset, synchronous, active-high
//   PSEL     in   1   select from master
//   PENABLE  in   1   access-phase strobe from master
//   PWRITE   in   1   1 = write, 0 = read
//   PADDR    in   8   register index; no byte-lane scaling
//   PWDATA   in   32  write data
//   PRDATA   out  32  read data; valid while PREADY=1 on a read
//   PREADY   out  1   transfer completes in the cycle PREADY=1
//   PSLVERR  out  1   error response; valid only while PREADY=1
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset:
//     - takes effect on the PCLK edge where PRESET=1; this is the only clock/reset domain
//     - state=IDLE, wait counter=0, all registers=RST_VAL
//     - PRDATA=0, PREADY=0, PSLVERR=0
//     - reset mid-transfer aborts the transfer and the write is not committed
//   FSM states: IDLE, ACCESS, DONE.
//     - IDLE -> ACCESS on a setup cycle: PSEL=1 and PENABLE=0.
//       Latch PADDR, PWRITE, PWDATA; counter cleared to 0.
//     - ACCESS: counter increments each cycle while counter < WAIT_CYCLES.
//       PREADY = (state==ACCESS) && PSEL && PENABLE && (counter==WAIT_CYCLES), decoded combinationally from registered state.
//       WAIT_CYCLES=0 gives PREADY=1 in the first access cycle (cycle after setup).
//       WAIT_CYCLES=N gives PREADY=1 in access cycle N+1.
//     - ACCESS -> DONE on the edge ending the PREADY=1 cycle.
//     - DONE -> IDLE when PSEL=0 or PENABLE=0.
//       The master may hold PSEL/PENABLE high for cycles after completion; these never restart a transfer.
//       A new transfer needs a fresh setup cycle (PENABLE=0).
//       If the DONE -> IDLE exit cycle is itself a setup cycle (PSEL=1, PENABLE=0), the FSM goes directly to ACCESS
//       (back-to-back transfers allowed).
//     - Protocol abort: PSEL=0 while in ACCESS -> IDLE, no write, no response.
//       PENABLE=0 while in ACCESS with PSEL=1 is treated as a new setup cycle: relatch and restart.
//   Write:
//     - register[latched addr] <= latched PWDATA on the edge ending the PREADY=1 cycle, only if addr < DEPTH
//     - exactly one commit per transfer
//   Read:
//     - PRDATA = register[latched addr] while PREADY=1, else 0
//     - a same-index write committing on that edge is not visible until the next transfer
//   Errors:
//     - latched addr >= DEPTH: PSLVERR=1 with PREADY, write dropped, PRDATA=0; no state corruption
//   PSLVERR=0 whenever PREADY=0. Outputs never X after reset.
// TESTING
//   1 Reset: PRESET=1 two cycles mid-write of 32'hDEADBEEF to idx 3
//     -> PREADY=0, read idx 3 returns RST_VAL.
//   2 Write 32'h11223344 to idx 1, read idx 1, WAIT_CYCLES=1
//     -> PREADY high in 2nd access cycle, PRDATA=32'h11223344, PSLVERR=0.
//   3 Writes to idx 2,3,4 (32'h11112222, 32'h12233344, 32'h12344321) then read back each
//     -> exact data; idx 5 remains RST_VAL.
//   4 WAIT_CYCLES=0 and WAIT_CYCLES=3 builds
//     -> PREADY asserted in access cycle 1 and 4 respectively; one PREADY pulse per transfer.
//   5 Write idx 8'h20 (>= DEPTH) data 32'hA5A5A5A5
//     -> PSLVERR=1 with PREADY; read idx 8'h20 gives PSLVERR=1, PRDATA=0; idx 0 unchanged.
//   6 Master holds PSEL/PENABLE high 3 cycles past PREADY, then back-to-back setup
//     -> no second commit; next transfer completes normally; PSEL drop mid-ACCESS commits nothing.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with a wait-stated 32-bit register bank
//
// Purpose:
//   Terminates APB transfers from an upstream master. It holds DEPTH 32-bit
//   registers indexed directly by PADDR, inserts WAIT_CYCLES wait states per
//   transfer, and flags out-of-range indices with PSLVERR.
//
// Ports:
//   PCLK     in   1   clock, rising edge
//   PRESET   in   1   synchronous active-high reset
//   PSEL     in   1   completer select
//   PENABLE  in   1   access-phase strobe
//   PWRITE   in   1   1 = write, 0 = read
//   PADDR    in   8   register index (no byte-lane scaling)
//   PWDATA   in   32  write data
//   PRDATA   out  32  read data while PREADY=1, otherwise 0
//   PREADY   out  1   transfer completes in the cycle PREADY=1
//   PSLVERR  out  1   error response, only ever set together with PREADY

module apb_slave_regfile #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] RST_VAL     = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int             CNT_W   = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       lat_addr;
    logic             lat_write;
    logic [31:0]      lat_wdata;
    logic [31:0]      regs [0:DEPTH-1];

    logic        setup;
    logic        addr_ok;
    logic        commit;
    logic [31:0] rd_sel;

    // A setup cycle relatches the request from any state: it starts a transfer
    // from IDLE/DONE and restarts an unfinished one in ACCESS.
    assign setup   = PSEL && !PENABLE;
    assign addr_ok = int'(lat_addr) < DEPTH;

    assign PREADY  = (state == ST_ACCESS) && PSEL && PENABLE && (cnt == CNT_MAX);
    assign PSLVERR = PREADY && !addr_ok;
    assign commit  = PREADY && lat_write && addr_ok;

    // Read mux built as a compare loop so out-of-range indices never address
    // past the end of the array.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lat_addr == 8'(i)) begin
                rd_sel = regs[i];
            end
        end
    end

    assign PRDATA = (PREADY && addr_ok) ? rd_sel : 32'h0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (PREADY) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Holding PSEL/PENABLE high parks here; only a drop or a
                    // fresh setup cycle leaves.
                    if (setup) begin
                        state <= ST_ACCESS;
                    end else if (!PSEL || !PENABLE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt <= '0;
        end else if (setup) begin
            cnt <= '0;
        end else if ((state == ST_ACCESS) && PSEL && PENABLE && (cnt < CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
        end else if (setup) begin
            lat_addr  <= PADDR;
            lat_write <= PWRITE;
            lat_wdata <= PWDATA;
        end
    end

    // Commit happens on the edge ending the PREADY cycle, so a read in the
    // same transfer never observes it.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RST_VAL;
            end
        end else if (commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lat_addr == 8'(i)) begin
                    regs[i] <= lat_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - scoreboard bench for apb_slave_regfile at three wait-state settings

module tb_apb_slave_regfile;

    localparam int          DEPTH = 16;
    localparam logic [31:0] RV    = 32'hC0DE_5A00;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;

    logic [31:0] prdata0, prdata1, prdata2;
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .RST_VAL(RV)) u_w0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .RST_VAL(RV)) u_w1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .RST_VAL(RV)) u_w3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata2), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [31:0] mreg [0:2][0:DEPTH-1];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    function automatic int wc(int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] rd_of(int k);
        case (k)
            0:       return prdata0;
            1:       return prdata1;
            default: return prdata2;
        endcase
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut_wait=%0d cyc=%0d got=%h want=%h", name, wc(k), cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DEPTH; i++)
                mreg[k][i] = RV;
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic push_exp(int k, exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check_dut(int k);
        exp_t        e;
        bit          have;
        logic        rdy;
        logic        err;
        logic [31:0] dat;
        rdy  = pready[k];
        err  = pslverr[k];
        dat  = rd_of(k);
        have = 1'b0;
        if (rdy === 1'b1) begin
            case (k)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                chk("unexpected_pready", k, 32'(rdy), 32'd0);
            end else begin
                chk("complete_cycle", k, 32'(cyc), 32'(e.cyc));
                chk("pslverr", k, 32'(err), 32'(e.err));
                if (e.is_read || e.err)
                    chk("prdata", k, dat, e.data);
            end
        end else begin
            chk("pready_known", k, 32'(rdy), 32'd0);
            chk("idle_outputs", k, {dat[31:1], dat[0] | err}, 32'd0);
        end
    endtask

    always @(negedge PCLK) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) check_dut(k);
        end
    end

    task automatic drive(logic sel, logic en, logic wr, logic [7:0] addr, logic [31:0] data);
        @(posedge PCLK);
        #1;
        PSEL    = sel;
        PENABLE = en;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
    endtask

    // One setup cycle followed by n access cycles. Each DUT completes exactly
    // once, in access cycle W+1, if the master stays in access that long.
    task automatic do_xfer(logic wr, logic [7:0] addr, logic [31:0] data, int n, bit tail);
        int   s;
        exp_t e;
        drive(1'b1, 1'b0, wr, addr, data);
        s = cyc;
        for (int k = 0; k < 3; k++) begin
            if (n >= wc(k) + 1) begin
                e.is_read = !wr;
                e.err     = (int'(addr) >= DEPTH);
                e.data    = e.err ? 32'h0 : mreg[k][addr[3:0]];
                e.cyc     = s + wc(k) + 1;
                push_exp(k, e);
                if (wr && !e.err) mreg[k][addr[3:0]] = data;
            end
        end
        for (int j = 0; j < n; j++) drive(1'b1, 1'b1, wr, addr, data);
        if (!tail) drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        int          n;
        bit          t;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        model_reset();
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        mon_en = 1'b1;

        // Reset mid-write to index 3: the write must be dropped.
        drive(1'b1, 1'b0, 1'b1, 8'd3, 32'hDEADBEEF);
        @(posedge PCLK);
        #1;
        mon_en  = 1'b0;
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        for (int k = 0; k < 3; k++) begin
            chk("reset_pready", k, 32'(pready[k]), 32'd0);
            chk("reset_pslverr", k, 32'(pslverr[k]), 32'd0);
            chk("reset_prdata", k, rd_of(k), 32'd0);
        end
        model_reset();
        mon_en = 1'b1;
        do_xfer(1'b0, 8'd3, 32'h0, 4, 1'b0);

        // Basic write/read and multi-register readback.
        do_xfer(1'b1, 8'd1, 32'h11223344, 4, 1'b0);
        do_xfer(1'b0, 8'd1, 32'h0, 4, 1'b0);
        do_xfer(1'b1, 8'd2, 32'h11112222, 4, 1'b0);
        do_xfer(1'b1, 8'd3, 32'h12233344, 4, 1'b1);
        do_xfer(1'b1, 8'd4, 32'h12344321, 4, 1'b0);
        for (int i = 2; i <= 5; i++) do_xfer(1'b0, 8'(i), 32'h0, 4, 1'b0);

        // Out-of-range index.
        do_xfer(1'b1, 8'h20, 32'hA5A5A5A5, 4, 1'b0);
        do_xfer(1'b0, 8'h20, 32'h0, 4, 1'b0);
        do_xfer(1'b0, 8'd0, 32'h0, 4, 1'b0);

        // Held access past completion, back-to-back, aborts and restarts.
        do_xfer(1'b1, 8'd6, 32'h6666_0001, 7, 1'b1);
        do_xfer(1'b0, 8'd6, 32'h0, 4, 1'b1);
        do_xfer(1'b1, 8'd6, 32'h6666_0002, 4, 1'b0);
        do_xfer(1'b0, 8'd6, 32'h0, 4, 1'b0);
        do_xfer(1'b1, 8'd7, 32'h7777_0001, 0, 1'b0);
        do_xfer(1'b1, 8'd7, 32'h7777_0002, 1, 1'b0);
        do_xfer(1'b1, 8'd8, 32'h8888_0001, 2, 1'b1);
        do_xfer(1'b0, 8'd8, 32'h0, 4, 1'b0);
        do_xfer(1'b0, 8'd7, 32'h0, 4, 1'b0);

        // Randomized traffic.
        for (int r = 0; r < 120; r++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            d  = $urandom;
            n  = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 3) : $urandom_range(4, 7);
            t  = 1'($urandom_range(0, 1));
            do_xfer(wr, a, d, n, t);
        end
        for (int i = 0; i < DEPTH; i++) do_xfer(1'b0, 8'(i), 32'h0, 4, 1'b0);

        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("leftover_exp", 0, 32'(q0.size()), 32'd0);
        chk("leftover_exp", 1, 32'(q1.size()), 32'd0);
        chk("leftover_exp", 2, 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
